// File: rtl/decoder_arb_pkg.sv
// Shared definitions for the round-robin decoder arbiter: state encoding
// and requester count.
package decoder_arb_pkg;

    localparam int unsigned NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/decoder2x4_switch.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module decoder2x4_switch (
    input  logic [1:0] in,
    input  logic       en,
    output logic [3:0] result
);

    // One-hot decode of in, gated by en
    always_comb begin
        result = '0;
        if (en) begin
            result[in] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for a shared decoder resource. One owner at a time,
// no preemption, hold time bounded by HOLD_MAX cycles, and a one-cycle
// RELEASE gap before the next arbitration.
module decoder_rr_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    arb_state_t state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] id_nxt;
    logic [3:0] timer, timer_nxt;
    logic       timeout_nxt;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic       owner_req;

    // Next-owner search: first set request scanning from ptr upward, mod 4
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next-state, pointer, timer and timeout decisions
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        id_nxt      = gnt_id;
        timer_nxt   = timer;
        timeout_nxt = 1'b0;
        owner_req   = req[gnt_id];
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    id_nxt    = pick;
                    timer_nxt = '0;
                end
            end
            GRANT: begin
                if (done || !owner_req || (timer == HOLD_LAST)) begin
                    state_nxt   = RELEASE;
                    ptr_nxt     = gnt_id + 2'd1;
                    // Revocation is only reported when the owner still wanted it
                    timeout_nxt = (timer == HOLD_LAST) && !done && owner_req;
                end else begin
                    timer_nxt = timer + 4'd1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            timer   <= '0;
            gnt_id  <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            timer   <= timer_nxt;
            gnt_id  <= id_nxt;
            timeout <= timeout_nxt;
        end
    end

    // Busy while the resource is owned or being handed back
    always_comb begin
        busy = (state == GRANT) || (state == RELEASE);
    end

    decoder2x4_switch u_gnt_dec (
        .in     (gnt_id),
        .en     (state == GRANT),
        .result (gnt)
    );

endmodule
